stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: width in bits of each stack entry.
REQ-002 SHALL provide parameter DEPTH, default 16: maximum entry count; legal values are 2 and above, power of two.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port push, input, 1 bit: write data_in onto the stack.
REQ-006 SHALL provide port pop, input, 1 bit: remove the top entry.
REQ-007 SHALL provide port data_in, input, DATA_W bits: push/replace data.
REQ-008 SHALL provide port clr_err, input, 1 bit: clear the sticky error flags.
REQ-009 SHALL provide port tos, output, DATA_W bits: current top-of-stack value.
REQ-010 SHALL provide port count, output, $clog2(DEPTH+1) bits: current number of entries.
REQ-011 SHALL provide ports full and empty, output, 1 bit each: count==DEPTH and count==0 respectively.
REQ-012 SHALL provide ports ovf and udf, output, 1 bit each: sticky overflow and underflow flags.

Function
REQ-013 SHALL decode operations per cycle as: push only = PUSH; pop only = POP; push and pop = REPLACE; neither = HOLD.
REQ-014 PUSH with !full SHALL write data_in at index count and increment count; the new value appears on tos in the following cycle.
REQ-015 PUSH with full SHALL leave storage and count unchanged and set ovf.
REQ-016 POP with !empty SHALL decrement count; tos then shows the previous entry, with no read latency beyond the count update.
REQ-017 POP with empty SHALL leave state unchanged and set udf.
REQ-018 REPLACE with !empty SHALL overwrite entry count-1 with data_in and leave count unchanged; this is legal when full.
REQ-019 REPLACE with empty SHALL change nothing and set udf.
REQ-020 tos SHALL be combinational from entry count-1, and SHALL be all-zero when empty.
REQ-021 clr_err SHALL clear ovf and udf on the next edge; an error occurring in the same cycle SHALL win, so the flag stays set.
REQ-022 Entries at index count and above SHALL be don't-care and never observable on any output.

Reset
REQ-023 rst low SHALL immediately force count=0, empty=1, full=0, ovf=0, udf=0, tos=0, independent of clk.
REQ-024 Storage contents SHALL NOT be required to reset.
REQ-025 An operation in the cycle reset asserts SHALL be discarded; the first operation after release SHALL see an empty stack.

Configuration
REQ-026 With macro STACK_NOS_EN defined, the module SHALL add output nos (DATA_W bits) carrying entry count-2, zero when count<2, and updating with the same timing as tos.
REQ-027 Without STACK_NOS_EN, the nos port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package stack_pkg SHALL hold the op typedef (HOLD, PUSH, POP, REPLACE) and the default DATA_W and DEPTH constants.
REQ-029 Storage SHALL be a sub-module stack_ram (DEPTH x DATA_W, one synchronous write port, asynchronous read ports); pointer, flag and op-decode logic SHALL live in stack_unit.

Verification
REQ-030 Bench SHALL cover: reset, then push 0x11, 0x22, 0x33 -> count=3, tos=0x33 (nos=0x22 if enabled); pop -> tos=0x22, count=2.
REQ-031 Bench SHALL cover: DEPTH=4, push 4 values then push 0xAA -> full=1, ovf=1, count=4, tos is the 4th value; REPLACE with 0x5A -> tos=0x5A, count=4.
REQ-032 Bench SHALL cover: pop on empty -> udf=1, count=0, tos=0; REPLACE on empty -> udf=1, count=0.
REQ-033 Bench SHALL cover: ovf=1, then clr_err together with an overflowing push -> ovf stays 1; clr_err alone -> ovf=0 next cycle.
REQ-034 Bench SHALL cover: rst pulsed low mid-cycle with count=3 -> count=0 and empty=1 before the next clk edge; push 0x7E after release -> tos=0x7E, count=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack unit: operation encoding and default sizing.
package stack_pkg;

  localparam int STACK_DATA_W_DEF = 8;
  localparam int STACK_DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // Map the raw push/pop strobes onto a single operation per cycle.
  function automatic stack_op_e stack_decode(input logic push, input logic pop);
    stack_op_e op;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port, asynchronous reads.
// With STACK_NOS_EN defined a second read port supplies the next-of-stack entry.
// Contents are deliberately not reset; the pointer logic masks stale entries.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_top,
  output logic [DATA_W-1:0] rdata_top
`ifdef STACK_NOS_EN
  ,
  input  logic [AW-1:0]     raddr_nos,
  output logic [DATA_W-1:0] rdata_nos
`endif
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port, updated on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_top = mem_q[raddr_top];
`ifdef STACK_NOS_EN
  assign rdata_nos = mem_q[raddr_nos];
`endif

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with sticky overflow/underflow flags and combinational top-of-stack.
// Optional feature: define STACK_NOS_EN to add the next-of-stack output 'nos'.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W_DEF,
  parameter int DEPTH  = STACK_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          tos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
`ifdef STACK_NOS_EN
  ,
  output logic [DATA_W-1:0]          nos
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  stack_op_e         op;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ovf_evt, udf_evt;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_idx;
  logic [DATA_W-1:0] rdata_top;
  logic              is_full, is_empty;

  assign op       = stack_decode(push, pop);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign top_idx  = AW'(count_q - CW'(1));

  // Operation decode: next count, storage write and error events.
  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    waddr   = top_idx;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    case (op)
      OP_PUSH: begin
        if (is_full) begin
          ovf_evt = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = AW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          udf_evt = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      OP_REPLACE: begin
        if (is_empty) begin
          udf_evt = 1'b1;
        end else begin
          we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sticky flags: clear request loses to a same-cycle error.
  always_comb begin
    ovf_d = (clr_err ? 1'b0 : ovf_q) | ovf_evt;
    udf_d = (clr_err ? 1'b0 : udf_q) | udf_evt;
  end

  // Pointer and flag registers; reset empties the stack immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

`ifdef STACK_NOS_EN
  logic [AW-1:0]     nos_idx;
  logic [DATA_W-1:0] rdata_nos;
  assign nos_idx = AW'(count_q - CW'(2));
`endif

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (data_in),
    .raddr_top (top_idx),
    .rdata_top (rdata_top)
`ifdef STACK_NOS_EN
    ,
    .raddr_nos (nos_idx),
    .rdata_nos (rdata_nos)
`endif
  );

  assign tos   = is_empty ? '0 : rdata_top;
  assign count = count_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

`ifdef STACK_NOS_EN
  // Entries below the top are only visible once at least two are stacked.
  assign nos = (count_q < CW'(2)) ? '0 : rdata_nos;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (DEPTH=4, DATA_W=8).
module tb_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              clr_err;
  logic [DATA_W-1:0] tos;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;
`ifdef STACK_NOS_EN
  logic [DATA_W-1:0] nos;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stack_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .data_in (data_in),
    .clr_err (clr_err),
    .tos     (tos),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
`ifdef STACK_NOS_EN
    ,
    .nos     (nos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation for a single clock; returns 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic c);
    push    = p;
    pop     = q;
    data_in = d;
    clr_err = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    push    = 1'b1;
    pop     = 1'b0;
    data_in = 8'h99;
    clr_err = 1'b0;
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full),  0);
    check("rst_ovf",   32'(ovf),   0);
    check("rst_udf",   32'(udf),   0);
    check("rst_tos",   32'(tos),   0);
    @(posedge clk);
    #1;
    push = 1'b0;
    rst  = 1'b1;
    check("rst_discard_count", 32'(count), 0);

    // basic push/pop
    cycle(1, 0, 8'h11, 0);
    cycle(1, 0, 8'h22, 0);
    cycle(1, 0, 8'h33, 0);
    check("push3_count", 32'(count), 3);
    check("push3_tos",   32'(tos),   32'h33);
`ifdef STACK_NOS_EN
    check("push3_nos",   32'(nos),   32'h22);
`endif
    cycle(0, 1, 8'h00, 0);
    check("pop_tos",   32'(tos),   32'h22);
    check("pop_count", 32'(count), 2);
`ifdef STACK_NOS_EN
    check("pop_nos",   32'(nos),   32'h11);
`endif
    cycle(0, 1, 8'h00, 0);
    check("pop2_tos",  32'(tos),   32'h11);
`ifdef STACK_NOS_EN
    check("pop2_nos",  32'(nos),   0);
`endif
    cycle(0, 1, 8'h00, 0);
    check("pop3_empty", 32'(empty), 1);
    check("pop3_udf",   32'(udf),   0);

    // underflow
    cycle(0, 1, 8'h00, 0);
    check("udf_pop_flag",  32'(udf),   1);
    check("udf_pop_count", 32'(count), 0);
    check("udf_pop_tos",   32'(tos),   0);
    cycle(0, 0, 8'h00, 1);
    check("udf_clr", 32'(udf), 0);
    cycle(1, 1, 8'h44, 0);
    check("udf_rep_flag",  32'(udf),   1);
    check("udf_rep_count", 32'(count), 0);
    check("udf_rep_tos",   32'(tos),   0);
    cycle(0, 0, 8'h00, 1);
    check("udf_clr2", 32'(udf), 0);

    // fill and overflow
    cycle(1, 0, 8'hA1, 0);
    cycle(1, 0, 8'hA2, 0);
    cycle(1, 0, 8'hA3, 0);
    cycle(1, 0, 8'hA4, 0);
    check("fill_full",  32'(full),  1);
    check("fill_count", 32'(count), 4);
    check("fill_tos",   32'(tos),   32'hA4);
    check("fill_ovf",   32'(ovf),   0);
    cycle(1, 0, 8'hAA, 0);
    check("ovf_flag",  32'(ovf),   1);
    check("ovf_full",  32'(full),  1);
    check("ovf_count", 32'(count), 4);
    check("ovf_tos",   32'(tos),   32'hA4);
    cycle(1, 1, 8'h5A, 0);
    check("rep_full_tos",   32'(tos),   32'h5A);
    check("rep_full_count", 32'(count), 4);
`ifdef STACK_NOS_EN
    check("rep_full_nos",   32'(nos),   32'hA3);
`endif

    // clear vs. simultaneous error
    cycle(1, 0, 8'hBB, 1);
    check("clr_vs_ovf", 32'(ovf), 1);
    check("clr_vs_tos", 32'(tos), 32'h5A);
    cycle(0, 0, 8'h00, 1);
    check("clr_ovf", 32'(ovf), 0);

    // replace below full
    cycle(0, 1, 8'h00, 0);
    check("pop_after_full_tos", 32'(tos), 32'hA3);
    cycle(1, 1, 8'h3C, 0);
    check("rep_mid_tos",   32'(tos),   32'h3C);
    check("rep_mid_count", 32'(count), 3);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_tos",   32'(tos),   0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1, 0, 8'h7E, 0);
    check("post_rst_tos",   32'(tos),   32'h7E);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_udf",   32'(udf),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
